guess_entry: RTL
================

Name: guess_entry

Overview:
- Collects a three-digit guess from debounced keypad events and hands it to the game controller (control_game).
- Output: one iNumRdy-style pulse with three 4-bit digits.
- Provides a live view of the pending digits for the VGA text overlay.
- Enforces the game's entry rules: exactly 3 digits, all distinct, with edit keys and an error indicator.

Parameters:
- ERR_CYCLES, 25000000, cycles the err output stays high after a rejected key (0.5 s at 50 MHz); must be >= 1.
- CNT_W, 7, width of guess_cnt; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  single-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0x0-0x9 digit, 0xA DEL, 0xB CLR, 0xC ENT, 0xD-0xF ignored.
- lock  in  1  game over (4A); while high, every key except CLR is ignored.
- oNum1  out  4  submitted first digit (hundreds); held until next submit.
- oNum2  out  4  submitted second digit.
- oNum3  out  4  submitted third digit.
- oNumRdy  out  1  one-cycle pulse; oNum1..3 are valid in the same cycle.
- oEntry1  out  4  pending buffer digit 1, for display.
- oEntry2  out  4  pending buffer digit 2.
- oEntry3  out  4  pending buffer digit 3.
- digit_cnt  out  2  number of pending digits (0..3).
- err  out  1  rejected-key indicator.
- guess_cnt  out  CNT_W  number of accepted submissions, saturating.

Behaviour:
- Reset: state EMPTY. All outputs are zero, including buffer, oNum1..3, oNumRdy, err and guess_cnt.
- Reset mid-operation: discards the buffer and any pending pulse; there is no partial output.
- All outputs are registered. A key accepted at edge N is visible at edge N+1.
- States: EMPTY (cnt 0), PARTIAL (cnt 1-2), FULL (cnt 3), SUBMIT.
- SUBMIT lasts exactly one cycle, then goes to EMPTY.
- Digit d, cnt<3, d not in buffer:
  - Written at position cnt+1; cnt increments.
  - EMPTY goes to PARTIAL; cnt reaching 3 goes to FULL.
- Digit already in buffer (any position < cnt): rejected, buffer unchanged, err triggered.
- Digit while FULL: rejected, err triggered.
- DEL, cnt>0: clears position cnt to 0 and decrements cnt. Going from FULL gives PARTIAL; from cnt 1 gives EMPTY.
- DEL, cnt 0: ignored, no err.
- CLR: all entries cleared to 0, cnt 0, state EMPTY, err cleared immediately. Accepted even when lock is high.
- ENT while FULL:
  - oNum1..3 are loaded from the buffer and oNumRdy goes high for exactly one cycle.
  - The buffer clears, and guess_cnt increments (saturating, no wrap) in the same cycle.
  - State goes to SUBMIT.
- ENT with cnt<3: rejected, err triggered.
- key_valid during SUBMIT: dropped silently, no err.
- Codes 0xD-0xF: ignored, no err.
- lock high: digits, DEL and ENT are ignored with no err; lock never affects oNumRdy already issued.
- err trigger: err=1 for exactly ERR_CYCLES cycles starting the edge after the rejected key. A retrigger while high restarts the count.
- oNumRdy never pulses on two consecutive cycles. oNum1..3 change only on a submit edge.
- Only one key per cycle. Simultaneous key_valid and reset: reset wins.

Decomposition:
- Package game_pkg:
  - key code constants KEY_DEL=4'hA, KEY_CLR=4'hB, KEY_ENT=4'hC;
  - state encoding EMPTY/PARTIAL/FULL/SUBMIT;
  - digit type (4-bit).
- One sub-module, entry_err_timer:
  - inputs trigger and clear; output err;
  - down-counter of $clog2(ERR_CYCLES+1) bits; reload on trigger, zero on clear.
- Duplicate check (three 4-bit compares, masked by cnt) stays inline.

Test Plan:
- Keys 1,2,3,ENT → oNumRdy pulse for 1 cycle with oNum1..3 = 1,2,3, guess_cnt=1, digit_cnt=0 and buffer 0 on the next cycle.
- Keys 4,4 → second 4 rejected: digit_cnt=1, err high for exactly ERR_CYCLES (bench ERR_CYCLES=5).
- Keys 5,6,7,8,DEL,9,ENT → 8 gives err, DEL removes 7, submit gives 5,6,9.
- ENT with digit_cnt=2 → no oNumRdy, err asserted. CLR during err → err=0 next cycle, digit_cnt=0.
- Set lock=1, keys 1,2,3,ENT → no change and no pulse. CLR still clears. Deassert lock, repeat the keys → pulse with 1,2,3.
- Assert reset asynchronously in the middle of FULL and mid-err → all outputs are 0 before the next clk edge. guess_cnt saturates at 127 after 130 submits (CNT_W=7).

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the guess entry path.
// Contents: key codes for the edit keys, the entry FSM state type, the
// digit type and a helper that classifies a key code as a digit.
package game_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned DCNT_W  = 2;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t KEY_DEL = 4'hA;
  localparam digit_t KEY_CLR = 4'hB;
  localparam digit_t KEY_ENT = 4'hC;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2,
    SUBMIT  = 2'd3
  } state_t;

  function automatic logic is_digit(input digit_t code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/guess_entry_if.sv
// Keypad-to-game bundle for guess_entry.
// slave  : keypad events and lock in; submitted guess, live buffer,
//          digit count, error flag and guess counter out.
// master : mirror view for the driving side.
interface guess_entry_if #(
  parameter int unsigned CNT_W = 7
);
  import game_pkg::*;

  logic             key_valid;
  digit_t           key_code;
  logic             lock;
  digit_t           oNum1;
  digit_t           oNum2;
  digit_t           oNum3;
  logic             oNumRdy;
  digit_t           oEntry1;
  digit_t           oEntry2;
  digit_t           oEntry3;
  logic [DCNT_W-1:0] digit_cnt;
  logic             err;
  logic [CNT_W-1:0] guess_cnt;

  modport slave (
    input  key_valid, key_code, lock,
    output oNum1, oNum2, oNum3, oNumRdy,
    output oEntry1, oEntry2, oEntry3, digit_cnt, err, guess_cnt
  );

  modport master (
    output key_valid, key_code, lock,
    input  oNum1, oNum2, oNum3, oNumRdy,
    input  oEntry1, oEntry2, oEntry3, digit_cnt, err, guess_cnt
  );

endinterface

// File: rtl/entry_err_timer.sv
// Rejected-key indicator: err is high for ERR_CYCLES cycles after a trigger.
// Ports: clk, reset (async, active high), trigger (reload), clear (force
// low), err (registered).
module entry_err_timer #(
  parameter int unsigned ERR_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic clear,
  output logic err
);

  localparam int unsigned TW = $clog2(ERR_CYCLES + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Clear beats trigger; a retrigger while running restarts the window.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (trigger) begin
      count_d = TW'(ERR_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      err     <= 1'b0;
    end else begin
      count_q <= count_d;
      err     <= (count_d != '0);
    end
  end

endmodule

// File: rtl/guess_entry.sv
// Collects a three-distinct-digit guess from keypad events and issues it
// to the game controller as a one-cycle oNumRdy pulse.
// Ports: clk, reset (async, active high), bus (guess_entry_if.slave):
//   key_valid/key_code/lock in; oNum1..3/oNumRdy submitted guess;
//   oEntry1..3/digit_cnt live buffer; err reject flag; guess_cnt submits.
module guess_entry
  import game_pkg::*;
#(
  parameter int unsigned ERR_CYCLES = 25000000,
  parameter int unsigned CNT_W      = 7
) (
  input  logic clk,
  input  logic reset,
  guess_entry_if.slave bus
);

  state_t              state_q, state_d;
  digit_t [2:0]        ent_q, ent_d;
  logic [DCNT_W-1:0]   cnt_q, cnt_d;
  digit_t [2:0]        num_q, num_d;
  logic                rdy_q, rdy_d;
  logic [CNT_W-1:0]    gcnt_q, gcnt_d;
  logic                err_trig;
  logic                err_clr;
  logic                dup;

  // Duplicate check against the occupied buffer positions only.
  assign dup = ((cnt_q > 2'd0) && (ent_q[0] == bus.key_code)) ||
               ((cnt_q > 2'd1) && (ent_q[1] == bus.key_code)) ||
               ((cnt_q > 2'd2) && (ent_q[2] == bus.key_code));

  // Next-state and datapath decode.
  always_comb begin
    state_d  = state_q;
    ent_d    = ent_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    rdy_d    = 1'b0;
    gcnt_d   = gcnt_q;
    err_trig = 1'b0;
    err_clr  = 1'b0;

    if (state_q == SUBMIT) begin
      // Keys arriving during the submit cycle are dropped.
      state_d = EMPTY;
    end else if (bus.key_valid) begin
      if (bus.key_code == KEY_CLR) begin
        ent_d   = '0;
        cnt_d   = '0;
        state_d = EMPTY;
        err_clr = 1'b1;
      end else if (!bus.lock) begin
        if (is_digit(bus.key_code)) begin
          if ((cnt_q == 2'd3) || dup) begin
            err_trig = 1'b1;
          end else begin
            case (cnt_q)
              2'd0:    ent_d[0] = bus.key_code;
              2'd1:    ent_d[1] = bus.key_code;
              default: ent_d[2] = bus.key_code;
            endcase
            cnt_d   = cnt_q + 2'd1;
            state_d = (cnt_q == 2'd2) ? FULL : PARTIAL;
          end
        end else if (bus.key_code == KEY_DEL) begin
          if (cnt_q != 2'd0) begin
            case (cnt_q)
              2'd1:    ent_d[0] = '0;
              2'd2:    ent_d[1] = '0;
              default: ent_d[2] = '0;
            endcase
            cnt_d   = cnt_q - 2'd1;
            state_d = (cnt_q == 2'd1) ? EMPTY : PARTIAL;
          end
        end else if (bus.key_code == KEY_ENT) begin
          if (state_q == FULL) begin
            num_d   = ent_q;
            rdy_d   = 1'b1;
            ent_d   = '0;
            cnt_d   = '0;
            state_d = SUBMIT;
            if (gcnt_q != '1) begin
              gcnt_d = gcnt_q + CNT_W'(1);
            end
          end else begin
            err_trig = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      ent_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      rdy_q   <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      rdy_q   <= rdy_d;
      gcnt_q  <= gcnt_d;
    end
  end

  entry_err_timer #(
    .ERR_CYCLES(ERR_CYCLES)
  ) u_err_timer (
    .clk    (clk),
    .reset  (reset),
    .trigger(err_trig),
    .clear  (err_clr),
    .err    (bus.err)
  );

  assign bus.oNum1     = num_q[0];
  assign bus.oNum2     = num_q[1];
  assign bus.oNum3     = num_q[2];
  assign bus.oNumRdy   = rdy_q;
  assign bus.oEntry1   = ent_q[0];
  assign bus.oEntry2   = ent_q[1];
  assign bus.oEntry3   = ent_q[2];
  assign bus.digit_cnt = cnt_q;
  assign bus.guess_cnt = gcnt_q;

endmodule
